// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file plus ID/EX pipeline register feeding the ALU
// Optional same-cycle write-back bypass on the read ports: define OPFETCH_WB_BYPASS_EN.
module operand_fetch #(
  parameter int REG_BITS  = 32,
  parameter int ADDR_BITS = 5,
  parameter int CTRL_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_BITS-1:0] rs1,
  input  logic [ADDR_BITS-1:0] rs2,
  input  logic [ADDR_BITS-1:0] rd,
  input  logic [REG_BITS-1:0]  imm,
  input  logic                 use_imm,
  input  logic [CTRL_BITS-1:0] ctrl_in,
  input  logic                 wb_en,
  input  logic [ADDR_BITS-1:0] wb_addr,
  input  logic [REG_BITS-1:0]  wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_BITS-1:0]  A,
  output logic [REG_BITS-1:0]  B,
  output logic [CTRL_BITS-1:0] ctrl,
  output logic [ADDR_BITS-1:0] out_rd
);

  localparam int NREGS = 2 ** ADDR_BITS;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state;
  logic [REG_BITS-1:0]  rf [0:NREGS-1];
  logic [REG_BITS-1:0]  rd1;
  logic [REG_BITS-1:0]  rd2;
  logic                 accept;

  // Entry 0 is never written; the read mux below forces x0 to zero regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd1 = rf[rs1];
    rd2 = rf[rs2];
`ifdef OPFETCH_WB_BYPASS_EN
    if (wb_en && (wb_addr == rs1)) rd1 = wb_data;
    if (wb_en && (wb_addr == rs2)) rd2 = wb_data;
`endif
    if (rs1 == '0) rd1 = '0;
    if (rs2 == '0) rd2 = '0;
  end

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;

  // Flush wins over accept and hold; data regs are left stale on flush or drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      A      <= '0;
      B      <= '0;
      ctrl   <= '0;
      out_rd <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (accept) begin
      state  <= FULL;
      A      <= rd1;
      B      <= use_imm ? imm : rd2;
      ctrl   <= ctrl_in;
      out_rd <= rd;
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed, table-driven bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, use_imm, wb_en, out_valid, out_ready;
  logic [4:0]  rs1, rs2, rd, wb_addr, out_rd;
  logic [31:0] imm, wb_data, A, B;
  logic [3:0]  ctrl_in, ctrl;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm), .ctrl_in(ctrl_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ctrl(ctrl), .out_rd(out_rd)
  );

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  ctrl;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic [31:0] im, input logic ui, input logic [3:0] c);
    in_valid = 1'b1; rs1 = s1; rs2 = s2; rd = d; imm = im; use_imm = ui; ctrl_in = c;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic [4:0] r);
    chk({nm, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, ".A"}, A, a);
    chk({nm, ".B"}, B, b);
    chk({nm, ".ctrl"}, {28'd0, ctrl}, {28'd0, c});
    chk({nm, ".rd"}, {27'd0, out_rd}, {27'd0, r});
  endtask

  initial begin
    tbl[0] = '{rs1: 5,  rs2: 5,  rd: 3,  imm: 32'h0,        use_imm: 0, ctrl: 4'h0, exp_a: 32'h0000_000A, exp_b: 32'h0000_000A};
    tbl[1] = '{rs1: 0,  rs2: 9,  rd: 8,  imm: 32'hFFFF_FFFE, use_imm: 1, ctrl: 4'h1, exp_a: 32'h0,          exp_b: 32'hFFFF_FFFE};
    tbl[2] = '{rs1: 1,  rs2: 2,  rd: 31, imm: 32'h5555_5555, use_imm: 0, ctrl: 4'h2, exp_a: 32'h1111_1111, exp_b: 32'h2222_2222};
    tbl[3] = '{rs1: 31, rs2: 0,  rd: 0,  imm: 32'h0,        use_imm: 0, ctrl: 4'hF, exp_a: 32'hDEAD_BEEF, exp_b: 32'h0};
    tbl[4] = '{rs1: 2,  rs2: 31, rd: 17, imm: 32'h0000_0007, use_imm: 1, ctrl: 4'h3, exp_a: 32'h2222_2222, exp_b: 32'h0000_0007};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; imm = '0; use_imm = 1'b0; ctrl_in = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick();
    rst = 1'b0;
    wr(5'd3, 32'h33);
    // Write presented during reset must be dropped; earlier x3 write must be cleared.
    rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    tick(); tick();
    rst = 1'b0; wb_en = 1'b0;
    #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.A", A, 32'd0);
    chk("rst.B", B, 32'd0);
    chk("rst.ctrl", {28'd0, ctrl}, 32'd0);
    chk("rst.rd", {27'd0, out_rd}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(i[4:0], i[4:0], 5'd0, 32'h0, 1'b0, 4'h0);
      tick();
      chk($sformatf("rst.rd1[%0d]", i), A, 32'd0);
      chk($sformatf("rst.rd2[%0d]", i), B, 32'd0);
    end
    in_valid = 1'b0;
    tick();

    wr(5'd5, 32'h0000_000A);
    wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd1, 32'h1111_1111);
    wr(5'd2, 32'h2222_2222);
    wr(5'd31, 32'hDEAD_BEEF);

    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, tbl[i].use_imm, tbl[i].ctrl);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].exp_a, tbl[i].exp_b, tbl[i].ctrl, tbl[i].rd);
    end
    in_valid = 1'b0;
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    drive(5'd1, 5'd0, 5'd1, 32'h100, 1'b1, 4'h4);
    tick();
    chk_out("s.op1", 32'h1111_1111, 32'h100, 4'h4, 5'd1);
    drive(5'd2, 5'd0, 5'd2, 32'h200, 1'b1, 4'h5);
    out_ready = 1'b0;
    #1;
    chk("s.in_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    chk_out("s.hold1", 32'h1111_1111, 32'h100, 4'h4, 5'd1);
    chk("s.in_ready1", {31'd0, in_ready}, 32'd0);
    tick();
    chk_out("s.hold2", 32'h1111_1111, 32'h100, 4'h4, 5'd1);
    out_ready = 1'b1;
    #1;
    chk("s.in_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("s.op2", 32'h2222_2222, 32'h200, 4'h5, 5'd2);
    drive(5'd31, 5'd0, 5'd3, 32'h300, 1'b1, 4'h6);
    tick();
    chk_out("s.op3", 32'hDEAD_BEEF, 32'h300, 4'h6, 5'd3);
    in_valid = 1'b0;
    tick();
    chk("s.empty", {31'd0, out_valid}, 32'd0);

    drive(5'd1, 5'd0, 5'd4, 32'h5, 1'b1, 4'h7);
    tick();
    chk_out("f.full", 32'h1111_1111, 32'h5, 4'h7, 5'd4);
    drive(5'd2, 5'd0, 5'd5, 32'h6, 1'b1, 4'h8);
    out_ready = 1'b0; flush = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    tick();
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    chk("f.valid0", {31'd0, out_valid}, 32'd0);
    tick();
    chk("f.valid1", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(5'd6, 5'd0, 5'd6, 32'h0, 1'b0, 4'h0);
    tick();
    chk_out("f.wbcommit", 32'h66, 32'h0, 4'h0, 5'd6);

    drive(5'd7, 5'd0, 5'd7, 32'h0, 1'b0, 4'h0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    tick();
    wb_en = 1'b0;
`ifdef OPFETCH_WB_BYPASS_EN
    chk("byp.A", A, 32'h1234);
`else
    chk("byp.A", A, 32'h0);
`endif
    tick();
    chk("byp.after", A, 32'h1234);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
